// File: rtl/row_clearer.sv
// Line-clear stage: removes full rows bottom-up and collapses the board one step per cycle.
// Optional saturating score accumulator is built when ROW_CLEAR_SCORE_EN is defined.

module row_clearer_row #(
    parameter int COLS = 12
) (
    input  logic            i_shift,
    input  logic            i_top,
    input  logic [COLS-1:0] i_cur,
    input  logic [COLS-1:0] i_above,
    output logic [COLS-1:0] o_next
);
    always_comb begin
        o_next = i_cur;
        if (i_shift) o_next = i_top ? '0 : i_above;
    end
endmodule

module row_clearer #(
    parameter int COLS    = 12,
    parameter int ROWS    = 12,
    parameter int SCORE_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ROWS*COLS:0]   board_in,
    output logic                 busy,
    output logic                 done,
    output logic [ROWS*COLS:0]   board_out,
    output logic [3:0]           lines_cleared,
    output logic [SCORE_W-1:0]   score
);
    localparam int CW = ROWS * COLS;
    localparam int PW = $clog2(ROWS);

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t           r_state, w_next_state;
    logic [CW-1:0]    r_work;
    logic [CW-1:0]    w_work_nx;
    logic [PW-1:0]    r_ptr;
    logic [3:0]       r_cnt;
    logic             r_done;
    logic [CW-1:0]    r_board_out;
    logic [3:0]       r_lines;
    logic [COLS-1:0]  w_row;
    logic             w_full;
    logic             w_load, w_shift, w_dec, w_finish;
    logic             w_unused;

    assign w_unused = board_in[CW];
    assign w_row    = r_work[int'(r_ptr)*COLS +: COLS];
    assign w_full   = &w_row;

    // A clear shifts every row at or above the pointer down by one in a single cycle.
    for (genvar k = 0; k < ROWS; k++) begin : g_row
        logic [COLS-1:0] w_above;
        if (k == 0) begin : g_top
            assign w_above = '0;
        end else begin : g_mid
            assign w_above = r_work[(k-1)*COLS +: COLS];
        end
        row_clearer_row #(.COLS(COLS)) u_row (
            .i_shift (w_shift && (r_ptr >= PW'(k))),
            .i_top   (k == 0),
            .i_cur   (r_work[k*COLS +: COLS]),
            .i_above (w_above),
            .o_next  (w_work_nx[k*COLS +: COLS])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_dec        = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_full) begin
                    w_shift = 1'b1;
                end else if (r_ptr != '0) begin
                    w_dec = 1'b1;
                end else begin
                    w_finish     = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_work      <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_board_out <= '0;
            r_lines     <= '0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_work <= board_in[CW-1:0];
                r_ptr  <= PW'(ROWS - 1);
                r_cnt  <= '0;
            end else if (w_shift) begin
                r_work <= w_work_nx;
                r_cnt  <= r_cnt + 4'd1;
            end else if (w_dec) begin
                r_ptr <= r_ptr - PW'(1);
            end
            if (w_finish) begin
                r_board_out <= r_work;
                r_lines     <= r_cnt;
            end
        end
    end

`ifdef ROW_CLEAR_SCORE_EN
    logic [SCORE_W-1:0] r_score;
    logic [4:0]         w_weight;
    logic [SCORE_W:0]   w_sum;

    // Weight is 2L-1 for L>0; the add saturates instead of wrapping.
    assign w_weight = (r_cnt == 4'd0) ? 5'd0 : ({1'b0, r_cnt} << 1) - 5'd1;
    assign w_sum    = {1'b0, r_score} + (SCORE_W+1)'(w_weight);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_score <= '0;
        end else if (w_finish) begin
            r_score <= w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
        end
    end

    assign score = r_score;
`else
    assign score = '0;
`endif

    assign busy          = (r_state == S_SCAN);
    assign done          = r_done;
    assign board_out     = {1'b0, r_board_out};
    assign lines_cleared = r_lines;
endmodule

// File: tb/tb_row_clearer.sv
// Self-checking bench for row_clearer: directed test-plan boards plus random boards
// checked against a row-compaction reference model.

module tb_row_clearer;
    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [144:0] board_in;
    logic         busy;
    logic         done;
    logic [144:0] board_out;
    logic [3:0]   lines_cleared;
    logic [15:0]  score;

    int checks = 0;
    int errors = 0;
    int exp_score = 0;

    always #5 clk = ~clk;

    row_clearer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .board_in      (board_in),
        .busy          (busy),
        .done          (done),
        .board_out     (board_out),
        .lines_cleared (lines_cleared),
        .score         (score)
    );

    // Reference: keep non-full rows in bottom-up order, pad with empty rows on top.
    function automatic void model(input logic [144:0] b, output logic [144:0] ob, output int l);
        int w;
        ob = '0;
        l  = 0;
        w  = 11;
        for (int r = 11; r >= 0; r--) begin
            if (b[r*12 +: 12] == 12'hFFF) l++;
            else begin
                ob[w*12 +: 12] = b[r*12 +: 12];
                w--;
            end
        end
    endfunction

    task automatic add_score(input int l);
`ifdef ROW_CLEAR_SCORE_EN
        if (l > 0) exp_score = exp_score + 2*l - 1;
        if (exp_score > 65535) exp_score = 65535;
`endif
    endtask

    function automatic logic [144:0] rand_board();
        logic [144:0] b;
        logic [11:0]  row;
        b = '0;
        for (int r = 0; r < 12; r++) begin
            row = ($urandom_range(2) == 0) ? 12'hFFF : 12'($urandom);
            b[r*12 +: 12] = row;
        end
        b[144] = 1'($urandom_range(1));
        return b;
    endfunction

    // Runs one pass; returns done latency in edges after E0 (-1 on timeout).
    task automatic do_pass(input logic [144:0] b, input bit chain,
                           output int lat, output int busy_bad, output logic busy_at_done);
        busy_bad     = 0;
        lat          = -1;
        busy_at_done = 1'bx;
        if (!chain) begin
            @(negedge clk);
            board_in = b;
            start    = 1'b1;
        end
        @(negedge clk);
        start    = 1'b0;
        board_in = ~b;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat          = k;
                busy_at_done = busy;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
        end
    endtask

    task automatic check_pass(input string name, input logic [144:0] b, input int lat,
                              input int busy_bad, input logic busy_at_done);
        logic [144:0] eb;
        int           l;
        model(b, eb, l);
        add_score(l);
        checks++;
        if (lat !== 12 + l) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, lat, 12 + l);
        end
        checks++;
        if (board_out !== eb) begin
            errors++;
            $display("FAIL %s board_out got %h want %h", name, board_out, eb);
        end
        checks++;
        if (lines_cleared !== 4'(l)) begin
            errors++;
            $display("FAIL %s lines_cleared got %0d want %0d", name, lines_cleared, l);
        end
        checks++;
        if (score !== 16'(exp_score)) begin
            errors++;
            $display("FAIL %s score got %0d want %0d", name, score, exp_score);
        end
        checks++;
        if (busy_bad !== 0 || busy_at_done !== 1'b0) begin
            errors++;
            $display("FAIL %s busy bad_cycles %0d busy_at_done %b want 0/0", name, busy_bad, busy_at_done);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        board_in = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, lines_cleared, score} !== '0 || board_out !== '0) begin
            errors++;
            $display("FAIL reset outputs busy %b done %b lines %0d score %0d board %h want all 0",
                     busy, done, lines_cleared, score, board_out);
        end
        reset = 1'b0;
        exp_score = 0;
    endtask

    task automatic test_directed();
        logic [144:0] b;
        int lat, bb;
        logic bd;
        b = '0;
        do_pass(b, 0, lat, bb, bd);
        check_pass("empty", b, lat, bb, bd);
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width got %b want 0", done);
        end
        b = '0; b[143:132] = '1; b[123] = 1'b1;
        do_pass(b, 0, lat, bb, bd);
        check_pass("single", b, lat, bb, bd);
        checks++;
        if (board_out !== (145'd1 << 135)) begin
            errors++;
            $display("FAIL single_bit135 got %h want bit 135 only", board_out);
        end
        b = '0; b[143:132] = '1; b[119:108] = '1; b[100] = 1'b1; b[125] = 1'b1;
        do_pass(b, 0, lat, bb, bd);
        check_pass("split", b, lat, bb, bd);
        b = '1;
        do_pass(b, 0, lat, bb, bd);
        check_pass("full", b, lat, bb, bd);
    endtask

    task automatic test_random();
        logic [144:0] b;
        int lat, bb;
        logic bd;
        for (int i = 0; i < 20; i++) begin
            b = rand_board();
            do_pass(b, 0, lat, bb, bd);
            check_pass("random", b, lat, bb, bd);
        end
    endtask

    task automatic test_back_to_back();
        logic [144:0] a, b;
        int lat, bb;
        logic bd;
        a = rand_board();
        b = rand_board();
        do_pass(a, 0, lat, bb, bd);
        check_pass("b2b_first", a, lat, bb, bd);
        board_in = b;
        start    = 1'b1;
        do_pass(b, 1, lat, bb, bd);
        check_pass("b2b_second", b, lat, bb, bd);
    endtask

    task automatic test_start_while_busy();
        logic [144:0] a, eb;
        int l, ndone, first;
        a = '0; a[143:132] = '1; a[59:48] = '1; a[5] = 1'b1;
        model(a, eb, l);
        add_score(l);
        @(negedge clk);
        board_in = a;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        first = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 3) begin
                start    = 1'b1;
                board_in = '1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) first = k;
            end
        end
        checks++;
        if (ndone !== 1 || first !== 12 + l) begin
            errors++;
            $display("FAIL busy_start dones %0d at %0d want 1 at %0d", ndone, first, 12 + l);
        end
        checks++;
        if (board_out !== eb || lines_cleared !== 4'(l) || score !== 16'(exp_score)) begin
            errors++;
            $display("FAIL busy_start result board %h lines %0d score %0d want %h %0d %0d",
                     board_out, lines_cleared, score, eb, l, exp_score);
        end
    endtask

    task automatic test_reset_mid_pass();
        logic [144:0] b;
        int lat, bb, nd;
        logic bd;
        @(negedge clk);
        board_in = '1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        exp_score = 0;
        checks++;
        if ({busy, done, lines_cleared, score} !== '0 || board_out !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs busy %b done %b lines %0d score %0d board %h want all 0",
                     busy, done, lines_cleared, score, board_out);
        end
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) nd++;
        end
        reset = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done activity_cycles %0d want 0", nd);
        end
        b = rand_board();
        do_pass(b, 0, lat, bb, bd);
        check_pass("after_reset", b, lat, bb, bd);
    endtask

`ifdef ROW_CLEAR_SCORE_EN
    task automatic test_saturation();
        logic [144:0] b;
        int lat, bb, bad;
        logic bd;
        b   = '1;
        bad = 0;
        for (int i = 0; i < 2852; i++) begin
            if (i != 0) begin
                board_in = b;
                start    = 1'b1;
            end
            do_pass(b, i != 0, lat, bb, bd);
            add_score(12);
            if (lat != 24 || score !== 16'(exp_score)) bad++;
        end
        checks++;
        if (bad !== 0 || score !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturation score %0d bad_passes %0d want 65535 and 0", score, bad);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid_pass();
`ifdef ROW_CLEAR_SCORE_EN
        test_saturation();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
